// File: rtl/cache_flush_seq.sv
// Cache flush sequencer: walks every set and way, writing back and
// clearing each valid+dirty line, then pulses FlushDone.
module cache_flush_seq #(
    parameter int NUMWAYS = 4,
    parameter int SETLEN  = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               FlushCache,
    input  logic [NUMWAYS-1:0] ValidWay,
    input  logic [NUMWAYS-1:0] DirtyWay,
    input  logic               WBAck,
    output logic [SETLEN-1:0]  FlushAdr,
    output logic [NUMWAYS-1:0] FlushWay,
    output logic               FlushAdrSel,
    output logic               WBReq,
    output logic               ClearDirty,
    output logic               Busy,
    output logic               FlushDone
);

    localparam int WAYW = $clog2(NUMWAYS);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CHECK,
        WB,
        CLR,
        DONE
    } state_e;

    state_e            state_q, state_d;
    state_e            adv_state;
    logic [SETLEN-1:0] set_q, set_d, adv_set;
    logic [WAYW-1:0]   way_q, way_d, adv_way;
    logic              last_way;
    logic              last_set;
    logic              line_dirty;

    assign last_way   = (way_q == WAYW'(NUMWAYS - 1));
    assign last_set   = &set_q;
    assign line_dirty = ValidWay[way_q] & DirtyWay[way_q];

    // Same-set steps stay in CHECK: the array data is still current.
    always_comb begin
        adv_state = CHECK;
        adv_set   = set_q;
        adv_way   = way_q + 1'b1;
        if (last_way) begin
            adv_way = '0;
            if (last_set) begin
                adv_state = DONE;
            end else begin
                adv_state = READ;
                adv_set   = set_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        set_d   = set_q;
        way_d   = way_q;
        unique case (state_q)
            IDLE: begin
                if (FlushCache) begin
                    state_d = READ;
                    set_d   = '0;
                    way_d   = '0;
                end
            end
            READ: begin
                state_d = CHECK;
            end
            CHECK: begin
                if (line_dirty) begin
                    state_d = WB;
                end else begin
                    state_d = adv_state;
                    set_d   = adv_set;
                    way_d   = adv_way;
                end
            end
            WB: begin
                if (WBAck) begin
                    state_d = CLR;
                end
            end
            CLR: begin
                state_d = adv_state;
                set_d   = adv_set;
                way_d   = adv_way;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            set_q   <= '0;
            way_q   <= '0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            way_q   <= way_d;
        end
    end

    assign FlushAdr    = set_q;
    assign Busy        = (state_q != IDLE);
    assign FlushAdrSel = Busy;
    assign WBReq       = (state_q == WB);
    assign ClearDirty  = (state_q == CLR);
    assign FlushDone   = (state_q == DONE);
    assign FlushWay    = (Busy && state_q != DONE)
                       ? (NUMWAYS'(1) << way_q) : '0;

endmodule

// File: tb/tb_cache_flush_seq.sv
// Directed bench for cache_flush_seq with a registered valid/dirty
// array model and a per-cycle monitor of each flush.
module tb_cache_flush_seq;

    localparam int NW = 4;
    localparam int SL = 7;
    localparam int NS = 1 << SL;

    logic          clk = 1'b0;
    logic          reset;
    logic          FlushCache;
    logic [NW-1:0] ValidWay;
    logic [NW-1:0] DirtyWay;
    logic          WBAck;
    logic [SL-1:0] FlushAdr;
    logic [NW-1:0] FlushWay;
    logic          FlushAdrSel;
    logic          WBReq;
    logic          ClearDirty;
    logic          Busy;
    logic          FlushDone;

    logic [NW-1:0] vmem [NS];
    logic [NW-1:0] dmem [NS];

    int n_chk  = 0;
    int n_pass = 0;

    int busy_cnt, done_cnt, done_cyc, wb_cyc, clr_cnt, clr_cyc;
    int adr_err, excl_err, oh_err, sel_err, wb_adr_err, tmo;
    int exp_wb_adr;
    logic [NW-1:0] exp_wb_way;

    cache_flush_seq #(.NUMWAYS(NW), .SETLEN(SL)) dut (
        .clk        (clk),
        .reset      (reset),
        .FlushCache (FlushCache),
        .ValidWay   (ValidWay),
        .DirtyWay   (DirtyWay),
        .WBAck      (WBAck),
        .FlushAdr   (FlushAdr),
        .FlushWay   (FlushWay),
        .FlushAdrSel(FlushAdrSel),
        .WBReq      (WBReq),
        .ClearDirty (ClearDirty),
        .Busy       (Busy),
        .FlushDone  (FlushDone)
    );

    always #5 clk = ~clk;

    // Arrays return the addressed set one cycle after FlushAdr.
    always_ff @(posedge clk) begin
        ValidWay <= vmem[FlushAdr];
        DirtyWay <= dmem[FlushAdr];
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < NS; i++) begin
            vmem[i] = '0;
            dmem[i] = '0;
        end
    endtask

    // Pulse FlushCache and monitor until Busy falls.
    task automatic run_flush(input int ack_lat, input int repulse,
                             input logic stray, input logic exact);
        int c, wb_run, prev_adr, slots;
        logic ended;
        busy_cnt = 0; done_cnt = 0; done_cyc = 0; wb_cyc = 0;
        clr_cnt = 0; clr_cyc = 0; adr_err = 0; excl_err = 0;
        oh_err = 0; sel_err = 0; wb_adr_err = 0; tmo = 0;
        wb_run = 0; prev_adr = 0; ended = 1'b0;
        FlushCache = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2000; k++) begin
            c = k + 1;
            if (!Busy) begin
                ended = 1'b1;
                break;
            end
            busy_cnt++;
            if (FlushAdrSel !== Busy) sel_err++;
            slots = int'(WBReq) + int'(ClearDirty) + int'(FlushDone);
            if (slots > 1) excl_err++;
            if (FlushDone) begin
                done_cnt++;
                done_cyc = c;
                if (FlushWay !== '0) oh_err++;
            end else begin
                if (!$onehot(FlushWay)) oh_err++;
                if (exact && int'(FlushAdr) != (c - 1) / 5) adr_err++;
                if (int'(FlushAdr) != prev_adr &&
                    int'(FlushAdr) != prev_adr + 1) adr_err++;
                prev_adr = int'(FlushAdr);
            end
            if (ClearDirty) begin
                clr_cnt++;
                clr_cyc = c;
            end
            if (WBReq) begin
                wb_cyc++;
                wb_run++;
                if (int'(FlushAdr) != exp_wb_adr || FlushWay != exp_wb_way)
                    wb_adr_err++;
                WBAck = (wb_run >= ack_lat);
            end else begin
                wb_run = 0;
                WBAck = stray;
            end
            FlushCache = (c == repulse) || (repulse > 0 && FlushDone);
            @(negedge clk);
        end
        FlushCache = 1'b0;
        WBAck = 1'b0;
        if (!ended) tmo = 1;
    endtask

    initial begin
        int err;
        clear_mem();
        reset = 1'b0;
        FlushCache = 1'b0;
        WBAck = 1'b0;
        exp_wb_adr = 0;
        exp_wb_way = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(Busy), 0);
        check("rst_sel", int'(FlushAdrSel), 0);
        check("rst_adr", int'(FlushAdr), 0);
        check("rst_way", int'(FlushWay), 0);
        check("rst_pulses", int'({WBReq, ClearDirty, FlushDone}), 0);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_hold", int'(Busy), 0);

        // All clean, exact address walk.
        run_flush(1, 0, 1'b0, 1'b1);
        check("clean_tmo", tmo, 0);
        check("clean_busy", busy_cnt, 641);
        check("clean_done", done_cnt, 1);
        check("clean_wb", wb_cyc, 0);
        check("clean_clr", clr_cnt, 0);
        check("clean_adr", adr_err, 0);
        check("clean_oh", oh_err, 0);
        check("clean_sel", sel_err, 0);
        check("clean_excl", excl_err, 0);

        // Set 5 way 2 dirty, ack on third WB cycle.
        vmem[5] = 4'b0100; dmem[5] = 4'b0100;
        exp_wb_adr = 5; exp_wb_way = 4'b0100;
        run_flush(3, 0, 1'b0, 1'b0);
        check("d5_busy", busy_cnt, 645);
        check("d5_wb", wb_cyc, 3);
        check("d5_wbadr", wb_adr_err, 0);
        check("d5_clr", clr_cnt, 1);
        check("d5_done", done_cnt, 1);
        check("d5_excl", excl_err, 0);
        clear_mem();

        // Last line dirty, immediate ack.
        vmem[127] = 4'b1000; dmem[127] = 4'b1000;
        exp_wb_adr = 127; exp_wb_way = 4'b1000;
        run_flush(1, 0, 1'b0, 1'b0);
        check("d127_busy", busy_cnt, 643);
        check("d127_wb", wb_cyc, 1);
        check("d127_wbadr", wb_adr_err, 0);
        check("d127_clr_cyc", clr_cyc, 642);
        check("d127_done_cyc", done_cyc, 643);
        check("d127_nowrap", adr_err, 0);
        check("d127_oh", oh_err, 0);
        clear_mem();

        // Dirty but invalid line, with stray WBAck outside WB.
        vmem[10] = 4'b0000; dmem[10] = 4'b0010;
        run_flush(1, 0, 1'b1, 1'b1);
        check("inv_wb", wb_cyc, 0);
        check("inv_busy", busy_cnt, 641);
        check("inv_clr", clr_cnt, 0);
        clear_mem();

        // Re-pulse at cycle 100 and during DONE.
        run_flush(1, 100, 1'b0, 1'b1);
        check("rep_done", done_cnt, 1);
        check("rep_done_cyc", done_cyc, 641);
        check("rep_busy", busy_cnt, 641);
        repeat (2) @(negedge clk);
        check("rep_idle", int'(Busy), 0);

        // Reset in the middle of a writeback.
        vmem[2] = 4'b0001; dmem[2] = 4'b0001;
        FlushCache = 1'b1;
        @(negedge clk);
        FlushCache = 1'b0;
        err = 1;
        for (int k = 0; k < 100; k++) begin
            if (WBReq) begin
                err = 0;
                break;
            end
            @(negedge clk);
        end
        check("mid_wb_seen", err, 0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("mid_wbreq", int'(WBReq), 0);
        check("mid_busy", int'(Busy), 0);
        check("mid_sel", int'(FlushAdrSel), 0);
        check("mid_adr", int'(FlushAdr), 0);
        check("mid_way", int'(FlushWay), 0);
        @(negedge clk);
        reset = 1'b1;
        err = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (Busy || FlushDone || ClearDirty || WBReq) err++;
        end
        check("mid_after", err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
